// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the ID-stage redirect controller.
//   cf_op_t  : control-flow class of the instruction sitting in ID
//   state_t  : controller FSM states
//   RESET_PC : fetch address the PC unit starts from
//   ZERO_REG : hard-wired zero register, never a hazard source
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    CF_NONE = 3'd0,
    CF_BEQ  = 3'd1,
    CF_BNE  = 3'd2,
    CF_J    = 3'd3,
    CF_JAL  = 3'd4,
    CF_JR   = 3'd5
  } cf_op_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  // Stall counter width; stall parameters must fit below 2**CNT_W.
  localparam int CNT_W = 4;

  // Ops that consume their register operand in ID (compare / jump register).
  function automatic logic is_id_consumer(input logic [2:0] op);
    return (op == CF_BEQ) || (op == CF_BNE) || (op == CF_JR);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: ID/EX/MEM sideband in, PC-unit controls out.
//   slave  : the controller (consumes ID/EX/MEM info, drives PC controls)
//   master : the pipeline side (drives ID/EX/MEM info, observes PC controls)
interface pc_redirect_ctrl_if;
  // ID stage
  logic        id_valid;
  logic [2:0]  id_op;
  logic [31:0] id_pc;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  // EX / MEM producers
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  // PC unit controls
  logic        PcSel;
  logic        dojump;
  logic [31:0] branchAddr;
  logic [31:0] jumpAddr;
  logic        do_stall;
  logic        id_hold;
  logic        if_flush;

  modport slave (
    input  id_valid, id_op, id_pc, id_imm16, id_index26, id_rs, id_rt,
           id_uses_rs, id_uses_rt, rs_val, rt_val,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    output PcSel, dojump, branchAddr, jumpAddr, do_stall, id_hold, if_flush
  );

  modport master (
    output id_valid, id_op, id_pc, id_imm16, id_index26, id_rs, id_rt,
           id_uses_rs, id_uses_rt, rs_val, rt_val,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    input  PcSel, dojump, branchAddr, jumpAddr, do_stall, id_hold, if_flush
  );
endinterface

// File: rtl/pc_redirect_ctrl_target.sv
// pc_target_calc: combinational branch/jump target and branch condition.
//   i_op/i_pc/i_imm16/i_index26 : ID instruction fields
//   i_rs_val/i_rt_val           : forwarded operands
//   o_br_taken / o_jmp_taken    : redirect class (mutually exclusive by op)
//   o_br_target / o_jmp_target  : computed targets (32-bit wrap)
module pc_target_calc
  import pc_ctrl_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_index26,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic        o_br_taken,
  output logic        o_jmp_taken,
  output logic [31:0] o_br_target,
  output logic [31:0] o_jmp_target
);
  logic [31:0] w_pc4;
  logic        w_eq;

  assign w_pc4 = i_pc + 32'd4;
  assign w_eq  = (i_rs_val == i_rt_val);

  // Word offset, sign-extended and scaled to bytes.
  assign o_br_target  = w_pc4 + {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign o_jmp_target = (i_op == CF_JR) ? i_rs_val
                                        : {w_pc4[31:28], i_index26, 2'b00};

  assign o_br_taken  = ((i_op == CF_BEQ) && w_eq) || ((i_op == CF_BNE) && !w_eq);
  assign o_jmp_taken = (i_op == CF_J) || (i_op == CF_JAL) || (i_op == CF_JR);
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: ID-stage control-flow resolver and hazard stall generator.
//   Clk, ReSet : clock, synchronous active-high reset
//   bus        : pc_redirect_ctrl_if.slave (ID/EX/MEM info in, PC-unit controls out)
// All outputs are registered: a decision taken in cycle N is seen by the PC unit in N+1.
// Build option: DELAY_SLOT_EN -- the slot after a branch/jump executes, if_flush stays 0.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL    = 1,
  parameter int BRANCH_ALU_STALL  = 1,
  parameter int BRANCH_LOAD_STALL = 2
) (
  input  logic               Clk,
  input  logic               ReSet,
  pc_redirect_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] LD_USE = CNT_W'(LOAD_USE_STALL);
  localparam logic [CNT_W-1:0] BR_ALU = CNT_W'(BRANCH_ALU_STALL);
  localparam logic [CNT_W-1:0] BR_LD  = CNT_W'(BRANCH_LOAD_STALL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  function automatic logic [CNT_W-1:0] max_n(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Stall cycles one source operand needs against the EX/MEM producers.
  function automatic logic [CNT_W-1:0] opnd_need(
    input logic       use_r,
    input logic [4:0] r,
    input logic       id_cons,
    input logic       ex_ld,
    input logic       ex_wr,
    input logic [4:0] ex_rd,
    input logic       mem_ld,
    input logic [4:0] mem_rd
  );
    logic [CNT_W-1:0] n;
    n = '0;
    if (use_r && (r != ZERO_REG)) begin
      if (id_cons) begin
        if (ex_ld && (r == ex_rd)) n = max_n(n, BR_LD);
        if (ex_wr && (r == ex_rd)) n = max_n(n, BR_ALU);
        if (mem_ld && (r == mem_rd)) n = max_n(n, ONE);
      end else if (ex_ld && (r == ex_rd)) begin
        n = LD_USE;
      end
    end
    return n;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pcsel, r_dojump, r_stall, r_hold, r_flush;
  logic [31:0]      r_baddr, r_jaddr;

  logic             w_br_taken, w_jmp_taken;
  logic [31:0]      w_br_target, w_jmp_target;
  logic             w_id_cons;
  logic [CNT_W-1:0] w_need_rs, w_need_rt, w_need;
  logic             w_hazard, w_eval;

  pc_target_calc u_tgt (
    .i_op        (bus.id_op),
    .i_pc        (bus.id_pc),
    .i_imm16     (bus.id_imm16),
    .i_index26   (bus.id_index26),
    .i_rs_val    (bus.rs_val),
    .i_rt_val    (bus.rt_val),
    .o_br_taken  (w_br_taken),
    .o_jmp_taken (w_jmp_taken),
    .o_br_target (w_br_target),
    .o_jmp_target(w_jmp_target)
  );

  assign w_id_cons = is_id_consumer(bus.id_op);
  assign w_need_rs = opnd_need(bus.id_uses_rs, bus.id_rs, w_id_cons, bus.ex_mem_read,
                               bus.ex_reg_write, bus.ex_rd, bus.mem_mem_read, bus.mem_rd);
  assign w_need_rt = opnd_need(bus.id_uses_rt, bus.id_rt, w_id_cons, bus.ex_mem_read,
                               bus.ex_reg_write, bus.ex_rd, bus.mem_mem_read, bus.mem_rd);
  assign w_need    = bus.id_valid ? max_n(w_need_rs, w_need_rt) : '0;
  assign w_hazard  = (w_need != '0);

  // ID is (re)evaluated in RUN and in the last stall cycle, so a stalled
  // branch resolves straight out of the stall without an idle cycle.
  assign w_eval = (r_state == ST_RUN) || ((r_state == ST_STALL) && (r_cnt == '0));

  always_ff @(posedge Clk) begin
    if (ReSet) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_pcsel  <= 1'b0;
      r_dojump <= 1'b0;
      r_stall  <= 1'b0;
      r_hold   <= 1'b0;
      r_flush  <= 1'b0;
      r_baddr  <= '0;
      r_jaddr  <= '0;
    end else begin
      r_pcsel  <= 1'b0;
      r_dojump <= 1'b0;
      r_stall  <= 1'b0;
      r_hold   <= 1'b0;
      r_flush  <= 1'b0;
      if ((r_state == ST_STALL) && (r_cnt != '0)) begin
        r_cnt   <= r_cnt - ONE;
        r_stall <= 1'b1;
        r_hold  <= 1'b1;
      end else if (w_eval) begin
        if (w_hazard) begin
          // Stall wins over a redirect; the branch is resolved afterwards.
          r_state <= ST_STALL;
          r_cnt   <= w_need - ONE;
          r_stall <= 1'b1;
          r_hold  <= 1'b1;
        end else if (bus.id_valid && (w_br_taken || w_jmp_taken)) begin
          r_state <= ST_REDIR;
          if (w_br_taken) begin
            r_pcsel <= 1'b1;
            r_baddr <= w_br_target;
          end else begin
            r_dojump <= 1'b1;
            r_jaddr  <= w_jmp_target;
          end
`ifdef DELAY_SLOT_EN
          r_flush <= 1'b0;
`else
          r_flush <= 1'b1;
`endif
        end else begin
          r_state <= ST_RUN;
        end
      end else begin
        // REDIR lasts one cycle; ID content is ignored while it is shown.
        r_state <= ST_RUN;
      end
    end
  end

  assign bus.PcSel      = r_pcsel;
  assign bus.dojump     = r_dojump;
  assign bus.branchAddr = r_baddr;
  assign bus.jumpAddr   = r_jaddr;
  assign bus.do_stall   = r_stall;
  assign bus.id_hold    = r_hold;
  assign bus.if_flush   = r_flush;

  // Selector 2'b11 is illegal for the PC unit.
  a_sel_onehot: assert property (@(posedge Clk) disable iff (ReSet) !(r_pcsel && r_dojump));
endmodule
